// File: rtl/lamp_log_issue_ctrl_pkg.sv
// ============================================================================
// Module : lamp_log_issue_ctrl_pkg
// Brief  : Shared types, constants and the operand classifier for the log issue sequencer
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lamp_log_issue_ctrl_pkg;

  localparam int LAMP_FLOAT_DW   = 16;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;
  localparam logic [LAMP_FLOAT_DW-1:0] LAMP_CANONICAL_QNAN = 16'h7FC0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } logIssueState_t;

  typedef struct packed {
    logic timeout;
    logic toRound;
    logic underflow;
    logic overflow;
  } logResFlags_t;

  // Returns {isInf, isDN, isZ, isSNAN, isQNAN} for a packed bfloat16 operand.
  function automatic logic [4:0] FUNC_checkOperand(input logic [LAMP_FLOAT_DW-1:0] op);
    logic [LAMP_FLOAT_E_DW-1:0] e;
    logic [LAMP_FLOAT_F_DW-1:0] f;
    logic is_inf, is_dn, is_z, is_snan, is_qnan;
    e       = op[14:7];
    f       = op[6:0];
    is_inf  = (&e) && (f == '0);
    is_dn   = (e == '0) && (f != '0);
    is_z    = (e == '0) && (f == '0);
    is_snan = (&e) && (f != '0) && !f[6];
    is_qnan = (&e) && f[6];
    return {is_inf, is_dn, is_z, is_snan, is_qnan};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lamp_log_issue_ctrl_if.sv
// ============================================================================
// Module : lamp_log_issue_ctrl_if
// Brief  : Operand stream, log-core handshake and result stream of the issue sequencer
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lamp_log_issue_ctrl_if;
  import lamp_log_issue_ctrl_pkg::*;

  logic                       op_valid_i;
  logic                       op_ready_o;
  logic [LAMP_FLOAT_DW-1:0]   op_i;

  logic                       doLog_o;
  logic                       s_op_o;
  logic [LAMP_FLOAT_E_DW-1:0] e_op_o;
  logic [LAMP_FLOAT_F_DW-1:0] f_op_o;
  logic                       isZ_op_o;
  logic                       isInf_op_o;
  logic                       isSNAN_op_o;
  logic                       isQNAN_op_o;
  logic                       isDN_op_o;

  logic                       s_res_i;
  logic [LAMP_FLOAT_E_DW-1:0] e_res_i;
  logic [LAMP_FLOAT_F_DW-1:0] f_res_i;
  logic                       valid_i;
  logic                       isOverflow_i;
  logic                       isUnderflow_i;
  logic                       isToRound_i;

  logic                       res_valid_o;
  logic                       res_ready_i;
  logic [LAMP_FLOAT_DW-1:0]   res_o;
  logic [3:0]                 res_flags_o;
  logic                       busy_o;

  modport slave (
    input  op_valid_i, op_i,
    input  s_res_i, e_res_i, f_res_i, valid_i, isOverflow_i, isUnderflow_i, isToRound_i,
    input  res_ready_i,
    output op_ready_o, doLog_o, s_op_o, e_op_o, f_op_o,
    output isZ_op_o, isInf_op_o, isSNAN_op_o, isQNAN_op_o, isDN_op_o,
    output res_valid_o, res_o, res_flags_o, busy_o
  );

  modport master (
    output op_valid_i, op_i,
    output s_res_i, e_res_i, f_res_i, valid_i, isOverflow_i, isUnderflow_i, isToRound_i,
    output res_ready_i,
    input  op_ready_o, doLog_o, s_op_o, e_op_o, f_op_o,
    input  isZ_op_o, isInf_op_o, isSNAN_op_o, isQNAN_op_o, isDN_op_o,
    input  res_valid_o, res_o, res_flags_o, busy_o
  );

endinterface

`default_nettype wire

// File: rtl/lamp_log_issue_ctrl_fifo.sv
// ============================================================================
// Module : lamp_log_res_fifo
// Brief  : First-word-fall-through result FIFO with synchronous reset
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lamp_log_res_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  // A pop frees the head slot in the same edge, so a full FIFO may still accept.
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/lamp_log_issue_ctrl.sv
// ============================================================================
// Module : lamp_log_issue_ctrl
// Brief  : Issues bfloat16 operands to lampFPU_log one at a time and queues results
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lamp_log_issue_ctrl
  import lamp_log_issue_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  lamp_log_issue_ctrl_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam int GW = $clog2(GAP_CYCLES+1);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int RW = LAMP_FLOAT_DW + 4;

  logIssueState_t           state_q, state_d;
  logic [TW-1:0]            tcnt_q, tcnt_d;
  logic [GW-1:0]            gap_q, gap_d;
  logic                     doLog_q, doLog_d;
  logic [LAMP_FLOAT_DW-1:0] op_q, op_d;
  logic [4:0]               cls_q, cls_d;
  logic                     rdy_en_q;

  logic                     op_ready;
  logic                     accept;
  logic                     push;
  logResFlags_t             push_flags;
  logic [LAMP_FLOAT_DW-1:0] push_res;
  logic                     fifo_valid;
  logic [RW-1:0]            fifo_data;
  logic [CW-1:0]            fifo_count;

  // rdy_en_q keeps op_ready_o low for the first cycle after reset release.
  assign op_ready = rdy_en_q && (state_q == IDLE) && (fifo_count < CW'(FIFO_DEPTH));
  assign accept   = bus.op_valid_i && op_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      gap_q    <= '0;
      doLog_q  <= 1'b0;
      op_q     <= '0;
      cls_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      gap_q    <= gap_d;
      doLog_q  <= doLog_d;
      op_q     <= op_d;
      cls_q    <= cls_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    gap_d      = gap_q;
    doLog_d    = doLog_q;
    op_d       = op_q;
    cls_d      = cls_q;
    push       = 1'b0;
    push_flags = '0;
    push_res   = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = bus.op_i;
          cls_d   = FUNC_checkOperand(bus.op_i);
          tcnt_d  = '0;
          doLog_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.valid_i) begin
          push                 = 1'b1;
          push_res             = {bus.s_res_i, bus.e_res_i, bus.f_res_i};
          push_flags.toRound   = bus.isToRound_i;
          push_flags.underflow = bus.isUnderflow_i;
          push_flags.overflow  = bus.isOverflow_i;
          doLog_d              = 1'b0;
          gap_d                = '0;
          state_d              = GAP;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES-1)) begin
          push               = 1'b1;
          push_res           = LAMP_CANONICAL_QNAN;
          push_flags.timeout = 1'b1;
          doLog_d            = 1'b0;
          gap_d              = '0;
          state_d            = GAP;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES-1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        doLog_d = 1'b0;
      end
    endcase
  end

  lamp_log_res_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({push_flags, push_res}),
    .pop_i   (bus.res_ready_i),
    .valid_o (fifo_valid),
    .data_o  (fifo_data),
    .count_o (fifo_count)
  );

  assign bus.op_ready_o  = op_ready;
  assign bus.doLog_o     = doLog_q;
  assign bus.s_op_o      = op_q[15];
  assign bus.e_op_o      = op_q[14:7];
  assign bus.f_op_o      = op_q[6:0];
  assign bus.isInf_op_o  = cls_q[4];
  assign bus.isDN_op_o   = cls_q[3];
  assign bus.isZ_op_o    = cls_q[2];
  assign bus.isSNAN_op_o = cls_q[1];
  assign bus.isQNAN_op_o = cls_q[0];
  assign bus.res_valid_o = fifo_valid;
  assign bus.res_o       = fifo_data[LAMP_FLOAT_DW-1:0];
  assign bus.res_flags_o = fifo_data[RW-1:LAMP_FLOAT_DW];
  assign bus.busy_o      = (state_q != IDLE);

endmodule

`default_nettype wire
